// File: rtl/pc_gen.sv
// Fetch-address generator: sequential increment, trap/jump redirects (captured
// while the pipeline is held) and a circular return-address stack for returns.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                HOLD_W     = 3,
  parameter int                RAS_DEPTH  = 4,
  parameter int                C_EXT      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              inst_len16_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_addr_o,
  output logic              redirect_o,
  output logic              ras_empty_o,
  output logic              ras_full_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Loaded targets are halfword aligned, or word aligned without compressed support.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r    = a;
    r[0] = 1'b0;
    if (C_EXT == 0) begin
      r[1] = 1'b0;
    end else begin
      r[1] = a[1];
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(0)) ? PTR_MAX : p - PTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_trap_q, pend_trap_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;

  logic              hold_s;
  logic              pop_s;
  logic              full_s;
  logic [ADDR_W-1:0] inc_s;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic              ras_we_s;
  logic [PTR_W-1:0]  ras_widx_s;

  assign hold_s    = (hold_flag_i != HOLD_W'(0));
  assign full_s    = (ras_cnt_q == CNT_MAX);
  assign pop_s     = ret_i && (ras_cnt_q != CNT_W'(0));
  assign inc_s     = ((C_EXT != 0) && inst_len16_i) ? ADDR_W'(2) : ADDR_W'(4);
  assign seq_s     = pc_q + inc_s;
  assign ras_top_s = ras_q[ras_ptr_q];

  // Next-state selection: redirect priority, pending capture and stack bookkeeping.
  always_comb begin
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_trap_d  = pend_trap_q;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    ras_we_s     = 1'b0;
    ras_widx_s   = ras_ptr_q;
    if (hold_s) begin
      // A pending trap may only be displaced by a newer trap.
      if (trap_flag_i) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = align_addr(trap_addr_i);
        pend_trap_d  = 1'b1;
      end else if (jump_flag_i && !(pend_valid_q && pend_trap_q)) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = align_addr(jump_addr_i);
        pend_trap_d  = 1'b0;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end else begin
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
      if (trap_flag_i) begin
        pc_d = align_addr(trap_addr_i);
      end else if (jump_flag_i) begin
        pc_d = align_addr(jump_addr_i);
      end else if (pend_valid_q) begin
        pc_d = pend_addr_q;
      end else if (pop_s) begin
        pc_d = ras_top_s;
      end else begin
        pc_d = seq_s;
      end
      redirect_d = trap_flag_i || jump_flag_i || pend_valid_q || pop_s;
      // Stack tracks call/ret regardless of which source wins the PC.
      case ({call_i, pop_s})
        2'b11: begin
          ras_we_s   = 1'b1;
          ras_widx_s = ras_ptr_q;
        end
        2'b10: begin
          ras_we_s   = 1'b1;
          ras_widx_s = ptr_inc(ras_ptr_q);
          ras_ptr_d  = ptr_inc(ras_ptr_q);
          ras_cnt_d  = full_s ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
        end
        2'b01: begin
          ras_ptr_d = ptr_dec(ras_ptr_q);
          ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
        default: begin
          ras_we_s = 1'b0;
        end
      endcase
    end
  end

  // Control and PC registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_ADDR;
      redirect_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= ADDR_W'(0);
      pend_trap_q  <= 1'b0;
      ras_ptr_q    <= PTR_W'(0);
      ras_cnt_q    <= CNT_W'(0);
    end else begin
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_trap_q  <= pend_trap_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
    end
  end

  // Return-address storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk_i) begin
    if (ras_we_s && !rst_i) begin
      ras_q[ras_widx_s] <= seq_s;
    end else begin
      ras_q[ras_widx_s] <= ras_q[ras_widx_s];
    end
  end

  assign pc_addr_o   = pc_q;
  assign redirect_o  = redirect_q;
  assign ras_empty_o = (ras_cnt_q == CNT_W'(0));
  assign ras_full_o  = full_s;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: two instances (compressed on/off) share stimulus
// and are compared against a queue-based reference model of the fetch rules.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hold;
  logic        jump, trap, len16, call, ret;
  logic [31:0] jaddr, taddr;

  logic [31:0] pc0, pc1;
  logic        red0, red1, emp0, emp1, full0, full1;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0000_0000), .HOLD_W(3), .RAS_DEPTH(DEPTH), .C_EXT(1)) u_c (
    .clk_i(clk), .rst_i(rst), .hold_flag_i(hold), .jump_flag_i(jump), .jump_addr_i(jaddr),
    .trap_flag_i(trap), .trap_addr_i(taddr), .inst_len16_i(len16), .call_i(call), .ret_i(ret),
    .pc_addr_o(pc0), .redirect_o(red0), .ras_empty_o(emp0), .ras_full_o(full0));

  pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0000_0000), .HOLD_W(3), .RAS_DEPTH(DEPTH), .C_EXT(0)) u_n (
    .clk_i(clk), .rst_i(rst), .hold_flag_i(hold), .jump_flag_i(jump), .jump_addr_i(jaddr),
    .trap_flag_i(trap), .trap_addr_i(taddr), .inst_len16_i(len16), .call_i(call), .ret_i(ret),
    .pc_addr_o(pc1), .redirect_o(red1), .ras_empty_o(emp1), .ras_full_o(full1));

  typedef struct packed {
    logic [31:0] pc;
    logic        red;
    logic        emp;
    logic        full;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, index 0 = compressed instance, 1 = word-only instance.
  logic [31:0] m_pc  [2];
  logic        m_red [2];
  logic        m_pv  [2];
  logic [31:0] m_pa  [2];
  logic        m_pt  [2];
  logic [31:0] ras0[$];
  logic [31:0] ras1[$];

  function automatic logic [31:0] aln(input logic [31:0] a, input bit cext);
    return cext ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
  endfunction

  function automatic int ras_size(input int k);
    return (k == 0) ? ras0.size() : ras1.size();
  endfunction

  function automatic logic [31:0] ras_pop(input int k);
    if (k == 0) return ras0.pop_back();
    else        return ras1.pop_back();
  endfunction

  task automatic ras_push(input int k, input logic [31:0] v);
    if (k == 0) begin
      ras0.push_back(v);
      if (ras0.size() > DEPTH) ras0.delete(0);
    end else begin
      ras1.push_back(v);
      if (ras1.size() > DEPTH) ras1.delete(0);
    end
  endtask

  task automatic ras_clear(input int k);
    if (k == 0) ras0.delete();
    else        ras1.delete();
  endtask

  task automatic model_step(input int k);
    bit          cext;
    bit          popped;
    logic [31:0] seq, nxt, top;
    obs_t        e;
    cext = (k == 0);
    if (rst) begin
      m_pc[k] = 32'h0000_0000; m_red[k] = 1'b0; m_pv[k] = 1'b0; m_pt[k] = 1'b0;
      ras_clear(k);
    end else if (hold != 3'd0) begin
      m_red[k] = 1'b0;
      if (trap) begin
        m_pv[k] = 1'b1; m_pa[k] = aln(taddr, cext); m_pt[k] = 1'b1;
      end else if (jump && !(m_pv[k] && m_pt[k])) begin
        m_pv[k] = 1'b1; m_pa[k] = aln(jaddr, cext); m_pt[k] = 1'b0;
      end
    end else begin
      seq    = m_pc[k] + ((cext && len16) ? 32'd2 : 32'd4);
      popped = ret && (ras_size(k) > 0);
      top    = 32'h0;
      if (popped) top = ras_pop(k);
      if (call) ras_push(k, seq);
      if (trap)         nxt = aln(taddr, cext);
      else if (jump)    nxt = aln(jaddr, cext);
      else if (m_pv[k]) nxt = m_pa[k];
      else if (popped)  nxt = top;
      else              nxt = seq;
      m_red[k] = trap || jump || m_pv[k] || popped;
      m_pv[k]  = 1'b0;
      m_pt[k]  = 1'b0;
      m_pc[k]  = nxt;
    end
    e.pc = m_pc[k]; e.red = m_red[k]; e.emp = (ras_size(k) == 0); e.full = (ras_size(k) == DEPTH);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One clock of stimulus; expectations for the following edge go to the scoreboard.
  task automatic cyc(input bit r, input logic [2:0] h, input bit j, input logic [31:0] ja,
                     input bit t, input logic [31:0] ta, input bit l16, input bit c, input bit rt);
    @(negedge clk); #1;
    rst = r; hold = h; jump = j; jaddr = ja; trap = t; taddr = ta; len16 = l16; call = c; ret = rt;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input bit l16);
    cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, l16, 1'b0, 1'b0);
  endtask

  task automatic check(input int k, input obs_t e, input obs_t a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL dut%0d pc/red/empty/full got %h/%b/%b/%b expected %h/%b/%b/%b",
               k, a.pc, a.red, a.emp, a.full, e.pc, e.red, e.emp, e.full);
    end
  endtask

  // Monitor: one output set per edge, compared against the oldest expectation.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check(0, e, {pc0, red0, emp0, full0});
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check(1, e, {pc1, red1, emp1, full1});
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 3'd0; jump = 1'b0; jaddr = 32'h0; trap = 1'b0; taddr = 32'h0;
    len16 = 1'b0; call = 1'b0; ret = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_red[k] = 1'b0; m_pv[k] = 1'b0; m_pa[k] = 32'h0; m_pt[k] = 1'b0;
    end

    cyc(1'b1, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 1'b1, 32'h44, 1'b1, 32'h88, 1'b0, 1'b1, 1'b1);
    // Sequential increments with alternating instruction length.
    for (int i = 0; i < 4; i++) idle(i[0]);
    // Address wrap.
    cyc(1'b0, 3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // Redirects captured while held; trap wins over the later jump.
    cyc(1'b0, 3'b010, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'b010, 1'b0, 32'h0,   1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'b010, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // Same-cycle trap and jump, then an unaligned jump target.
    cyc(1'b0, 3'd0, 1'b1, 32'h100, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 32'h103, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    // Fill the stack past its depth, then drain it and pop once more on empty.
    cyc(1'b0, 3'd0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) cyc(1'b0, 3'd0, 1'b1, 32'(i * 16), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    // Reset while a redirect is pending and the stack holds two entries.
    cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 3'd1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
          ($urandom_range(0, 7) == 0), $urandom(),
          ($urandom_range(0, 15) == 0), $urandom(),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end
    idle(1'b0);

    for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(posedge clk);
    #2;
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d/%0d pending expectations required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
